// File: rtl/uib_pkg.sv
// rtl/uib_pkg.sv - shared uib bus types and widths
// Purpose: access-mode and FSM state enums plus bus widths shared by the
//          core, the mmu and uib slaves.
// Ports:   none (package).
package uib_pkg;

  localparam int NUM_W = 3;
  localparam int DAT_W = 32;

  typedef enum logic [NUM_W-1:0] {
    MODE_B  = 3'b000,
    MODE_H  = 3'b001,
    MODE_W  = 3'b010,
    MODE_BU = 3'b100,
    MODE_HU = 3'b101
  } mode_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

endpackage

// File: rtl/uib_lane_unit.sv
// rtl/uib_lane_unit.sv - byte-lane steering and alignment check for uib slaves
// Purpose: combinational lane logic for a 32-bit word-organised slave.
// Ports:   mode   access mode (uib_pkg::mode_e encoding, other codes illegal)
//          off    byte offset within the word (addr[1:0])
//          wdata  right-aligned store data
//          rword  full RAM word being loaded
//          legal  1 when the mode is known and the offset is aligned
//          be     per-byte write enables (all zero when illegal)
//          wlanes store data replicated onto every lane
//          rdata  selected lane shifted to bit 0 and sign/zero extended
module uib_lane_unit
  import uib_pkg::*;
(
  input  logic [NUM_W-1:0] mode,
  input  logic [1:0]       off,
  input  logic [DAT_W-1:0] wdata,
  input  logic [DAT_W-1:0] rword,
  output logic             legal,
  output logic [3:0]       be,
  output logic [DAT_W-1:0] wlanes,
  output logic [DAT_W-1:0] rdata
);

  logic [DAT_W-1:0] rshift;

  always_comb begin
    rshift = rword >> {off, 3'b000};
    legal  = 1'b0;
    be     = 4'b0000;
    wlanes = wdata;
    rdata  = '0;
    case (mode)
      MODE_B, MODE_BU: begin
        legal  = 1'b1;
        be     = 4'b0001 << off;
        // Replication puts the byte on every lane; be picks the one written.
        wlanes = {4{wdata[7:0]}};
        rdata  = (mode == MODE_B) ? {{24{rshift[7]}}, rshift[7:0]}
                                  : {24'b0, rshift[7:0]};
      end
      MODE_H, MODE_HU: begin
        legal  = ~off[0];
        be     = off[0] ? 4'b0000 : (4'b0011 << off);
        wlanes = {2{wdata[15:0]}};
        rdata  = (mode == MODE_H) ? {{16{rshift[15]}}, rshift[15:0]}
                                  : {16'b0, rshift[15:0]};
      end
      MODE_W: begin
        legal = (off == 2'b00);
        be    = legal ? 4'b1111 : 4'b0000;
        rdata = rword;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/uib_ram_slave.sv
// rtl/uib_ram_slave.sv - word-organised RAM responder on a uib slave port
// Purpose: accepts one load/store, waits WAIT_CYCLES, then pulses ready for
//          one cycle with extended load data (and err on illegal access).
// Ports:   clk    system clock, rising edge
//          rst    asynchronous active-low reset
//          req    request strobe (sampled only in IDLE)
//          wen    1 = store, 0 = load
//          mode   access mode (B/H/W/BU/HU)
//          addr   byte address within this slave
//          dat_i  right-aligned store data
//          dat_o  right-aligned load data, valid with ready
//          ready  one-cycle completion pulse
//          err    one-cycle illegal-access flag coincident with ready
module uib_ram_slave
  import uib_pkg::*;
#(
  parameter int ADDR_W      = 29,
  parameter int DEPTH_LOG2  = 14,
  parameter int WAIT_CYCLES = 1,
  parameter     INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              wen,
  input  logic [NUM_W-1:0]  mode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DAT_W-1:0]  dat_i,
  output logic [DAT_W-1:0]  dat_o,
  output logic              ready,
  output logic              err
);

  localparam int LA_W  = DEPTH_LOG2 + 2;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  logic [DAT_W-1:0] mem [0:DEPTH-1];

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             lat_wen;
  logic [NUM_W-1:0] lat_mode;
  logic [LA_W-1:0]  lat_addr;
  logic [DAT_W-1:0] lat_dat;

  logic             sel_in;
  logic             acc_wen;
  logic [NUM_W-1:0] acc_mode;
  logic [LA_W-1:0]  acc_addr;
  logic [DAT_W-1:0] acc_dat;
  logic [DEPTH_LOG2-1:0] idx;
  logic             go_resp;
  logic             legal;
  logic [3:0]       be;
  logic [DAT_W-1:0] wlanes;
  logic [DAT_W-1:0] rdata;
  logic             unused_addr;

  // Bits above the RAM size are ignored so the array aliases.
  assign unused_addr = ^addr[ADDR_W-1:LA_W];

  // With WAIT_CYCLES=0 the response edge is the accept edge itself, so the
  // lane logic must see the live inputs in IDLE rather than the latched copy.
  assign sel_in   = (state == IDLE);
  assign acc_wen  = sel_in ? wen : lat_wen;
  assign acc_mode = sel_in ? mode : lat_mode;
  assign acc_addr = sel_in ? addr[LA_W-1:0] : lat_addr;
  assign acc_dat  = sel_in ? dat_i : lat_dat;
  assign idx      = acc_addr[LA_W-1:2];

  assign go_resp = ((state == IDLE) && req && (WAIT_CYCLES == 0)) ||
                   ((state == WAIT) && (cnt == '0));

  uib_lane_unit u_lane (
    .mode   (acc_mode),
    .off    (acc_addr[1:0]),
    .wdata  (acc_dat),
    .rword  (mem[idx]),
    .legal  (legal),
    .be     (be),
    .wlanes (wlanes),
    .rdata  (rdata)
  );

  // Commit on the edge entering RESP; rst gating drops a write that a
  // reset overlaps.
  always_ff @(posedge clk) begin
    if (go_resp && acc_wen && rst) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[idx][8*b +: 8] <= wlanes[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      ready    <= 1'b0;
      err      <= 1'b0;
      dat_o    <= '0;
      lat_wen  <= 1'b0;
      lat_mode <= '0;
      lat_addr <= '0;
      lat_dat  <= '0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      dat_o <= '0;
      case (state)
        IDLE: begin
          if (req) begin
            lat_wen  <= wen;
            lat_mode <= mode;
            lat_addr <= addr[LA_W-1:0];
            lat_dat  <= dat_i;
            if (WAIT_CYCLES > 0) begin
              state <= WAIT;
              cnt   <= CNT_W'(WAIT_CYCLES - 1);
            end else begin
              state <= RESP;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
      if (go_resp) begin
        ready <= 1'b1;
        err   <= ~legal;
        dat_o <= (legal && !acc_wen) ? rdata : '0;
      end
    end
  end

endmodule

// File: tb/tb_uib_ram_slave.sv
// tb/tb_uib_ram_slave.sv - scoreboard bench for uib_ram_slave
module tb_uib_ram_slave;

  localparam int LAT = 1;
  localparam int DL2 = 14;
  localparam logic [2:0] MB  = 3'b000;
  localparam logic [2:0] MH  = 3'b001;
  localparam logic [2:0] MW  = 3'b010;
  localparam logic [2:0] MBU = 3'b100;
  localparam logic [2:0] MHU = 3'b101;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        wen = 1'b0;
  logic [2:0]  mode = 3'b000;
  logic [28:0] addr = '0;
  logic [31:0] dat_i = '0;
  logic [31:0] dat_o;
  logic        ready;
  logic        err;

  typedef struct {
    logic [31:0] dat;
    logic        err;
    int          cyc;
    string       nm;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   resp_cnt = 0;
  logic chk_idle = 1'b0;

  uib_ram_slave #(
    .ADDR_W(29), .DEPTH_LOG2(DL2), .WAIT_CYCLES(LAT), .INIT_FILE("")
  ) dut (
    .clk(clk), .rst(rst), .req(req), .wen(wen), .mode(mode), .addr(addr),
    .dat_i(dat_i), .dat_o(dat_o), .ready(ready), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (chk_idle) begin
      checks += 3;
      if (ready !== 1'b0) begin errors++; $display("FAIL idle_ready got %b want 0", ready); end
      if (err !== 1'b0) begin errors++; $display("FAIL idle_err got %b want 0", err); end
      if (dat_o !== 32'h0) begin errors++; $display("FAIL idle_dat_o got %h want 0", dat_o); end
    end
    if (rst === 1'b1 && ready === 1'b1) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ready at cycle %0d dat_o=%h err=%b", cyc, dat_o, err);
      end else begin
        e = q.pop_front();
        checks += 3;
        if (dat_o !== e.dat) begin errors++; $display("FAIL %s dat_o got %h want %h", e.nm, dat_o, e.dat); end
        if (err !== e.err) begin errors++; $display("FAIL %s err got %b want %b", e.nm, err, e.err); end
        if (cyc != e.cyc) begin errors++; $display("FAIL %s latency ready cycle %0d want %0d", e.nm, cyc, e.cyc); end
      end
      resp_cnt++;
    end else if (q.size() > 0 && cyc > q[0].cyc + 2) begin
      e = q.pop_front();
      checks++; errors++;
      $display("FAIL %s timeout no ready by cycle %0d want %0d", e.nm, cyc, e.cyc);
      resp_cnt++;
    end
  end

  task automatic issue(input logic w, input logic [2:0] m, input logic [28:0] a,
                       input logic [31:0] d, input logic [31:0] ed, input logic ee,
                       input string nm);
    int target;
    exp_t x;
    @(negedge clk);
    target = resp_cnt + 1;
    req = 1'b1; wen = w; mode = m; addr = a; dat_i = d;
    x.dat = ed; x.err = ee; x.cyc = cyc + 1 + LAT; x.nm = nm;
    q.push_back(x);
    @(posedge clk); #1;
    // Scramble inputs after accept: only the latched copy may matter.
    req = 1'b0; wen = ~w; mode = MW; addr = 29'h0000_0ffc; dat_i = $urandom;
    for (int i = 0; i < 20 && resp_cnt < target; i++) @(posedge clk);
  endtask

  initial begin
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_idle = 1'b1;
    @(posedge clk); #1 chk_idle = 1'b0;
    @(negedge clk); rst = 1'b1;

    issue(1, MW,  29'h10, 32'hDEADBEEF, 32'h0, 0, "sw_10");
    issue(0, MW,  29'h10, 32'h0, 32'hDEADBEEF, 0, "lw_10");
    issue(1, MW,  29'h10, 32'h11223344, 32'h0, 0, "sw_10_b");
    issue(1, MB,  29'h11, 32'h000000A5, 32'h0, 0, "sb_11");
    issue(0, MW,  29'h10, 32'h0, 32'h1122A544, 0, "lw_after_sb");
    issue(0, MB,  29'h11, 32'h0, 32'hFFFFFFA5, 0, "lb_11");
    issue(0, MBU, 29'h11, 32'h0, 32'h000000A5, 0, "lbu_11");
    issue(0, MB,  29'h13, 32'h0, 32'h00000011, 0, "lb_13");
    issue(0, MH,  29'h10, 32'h0, 32'hFFFFA544, 0, "lh_10");
    issue(0, MHU, 29'h12, 32'h0, 32'h00001122, 0, "lhu_12");
    issue(1, MB,  29'h12, 32'hFFFFFF77, 32'h0, 0, "sb_12_junk");
    issue(0, MW,  29'h10, 32'h0, 32'h1177A544, 0, "lw_after_sb12");

    issue(1, MW,  29'h20, 32'hCAFEF00D, 32'h0, 0, "sw_20");
    issue(1, MH,  29'h22, 32'h00008001, 32'h0, 0, "sh_22");
    issue(0, MH,  29'h22, 32'h0, 32'hFFFF8001, 0, "lh_22");
    issue(0, MHU, 29'h22, 32'h0, 32'h00008001, 0, "lhu_22");
    issue(0, MW,  29'h20, 32'h0, 32'h8001F00D, 0, "lw_20");

    issue(0, MW,    29'h13, 32'h0, 32'h0, 1, "lw_13_misaligned");
    issue(1, MH,    29'h21, 32'h00001234, 32'h0, 1, "sh_21_misaligned");
    issue(0, MW,    29'h20, 32'h0, 32'h8001F00D, 0, "lw_20_unchanged");
    issue(0, 3'b111, 29'h20, 32'h0, 32'h0, 1, "mode_111");
    issue(1, 3'b011, 29'h20, 32'hFFFFFFFF, 32'h0, 1, "mode_011_store");
    issue(0, 3'b110, 29'h20, 32'h0, 32'h0, 1, "mode_110");
    issue(0, MW,    29'h20, 32'h0, 32'h8001F00D, 0, "lw_20_after_bad_mode");

    issue(1, MW, 29'h0, 32'h5A5A5A5A, 32'h0, 0, "sw_0");
    issue(0, MW, 29'(1 << (DL2 + 2)), 32'h0, 32'h5A5A5A5A, 0, "lw_alias");

    issue(1, MW, 29'h30, 32'h0, 32'h0, 0, "sw_30_zero");
    @(negedge clk);
    req = 1'b1; wen = 1'b1; mode = MW; addr = 29'h30; dat_i = 32'hFFFFFFFF;
    @(posedge clk); #1;
    req = 1'b0;
    rst = 1'b0;
    chk_idle = 1'b1;
    @(posedge clk); #1 chk_idle = 1'b0;
    @(negedge clk); rst = 1'b1;
    repeat (4) @(posedge clk);
    issue(0, MW, 29'h30, 32'h0, 32'h0, 0, "lw_30_after_reset");

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
